// File: rtl/photon_gate_sequencer_if.sv
// AXI-Stream result channel for the photon gate sequencer.
// master: tdata/tvalid out, tready in; slave: the reverse.
interface photon_gate_sequencer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/photon_gate_sequencer.sv
// Photon gate sequencer: timed counting windows, one-entry result register,
// stretched threshold trigger.
// Ports: clk/rst (async high), start/abort run control, edge_in photon
// pulses, cfg_* run config (latched on start), gate/busy/done status,
// m_axis result stream {window_idx, count}, trig_out trigger, overrun flag.
module photon_gate_sequencer #(
  parameter int TRIG_LEN    = 125,
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   edge_in,
  input  logic [TIMER_WIDTH-1:0] cfg_gate_len,
  input  logic [TIMER_WIDTH-1:0] cfg_dead_len,
  input  logic [15:0]            cfg_num_windows,
  input  logic [15:0]            cfg_threshold,
  output logic                   gate,
  output logic                   busy,
  output logic                   done,
  photon_gate_sequencer_if.master m_axis,
  output logic                   trig_out,
  output logic                   overrun
);

  localparam int TRIG_W = $clog2(TRIG_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_DEAD
  } state_t;

  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [TIMER_WIDTH-1:0] gate_len_q, gate_len_d;
  logic [TIMER_WIDTH-1:0] dead_len_q, dead_len_d;
  logic [15:0]            num_win_q, num_win_d;
  logic [15:0]            thr_q, thr_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            win_idx_q, win_idx_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   overrun_q, overrun_d;
  logic [TRIG_W-1:0]      trig_cnt_q, trig_cnt_d;
  logic                   trig_q, trig_d;
  logic                   gate_q, gate_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [15:0] cnt_inc;
  logic        close;
  logic        qualify;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gate_len_d = gate_len_q;
    dead_len_d = dead_len_q;
    num_win_d  = num_win_q;
    thr_d      = thr_q;
    count_d    = count_q;
    win_idx_d  = win_idx_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    overrun_d  = overrun_q;
    done_d     = 1'b0;
    close      = 1'b0;

    // Saturating count including this cycle's edge.
    cnt_inc = (edge_in && count_q != 16'hFFFF) ?
              count_q + 16'd1 : count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          gate_len_d = (cfg_gate_len == '0) ?
                       TIMER_WIDTH'(1) : cfg_gate_len;
          timer_d    = (cfg_gate_len == '0) ?
                       '0 : cfg_gate_len - 1'b1;
          dead_len_d = cfg_dead_len;
          num_win_d  = cfg_num_windows;
          thr_d      = cfg_threshold;
          count_d    = '0;
          win_idx_d  = '0;
          overrun_d  = 1'b0;
          state_d    = S_GATE;
        end
      end
      S_GATE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          close     = 1'b1;
          count_d   = '0;
          win_idx_d = win_idx_q + 16'd1;
          if (num_win_q != '0 && win_idx_d == num_win_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (dead_len_q == '0) begin
            timer_d = gate_len_q - 1'b1;
          end else begin
            state_d = S_DEAD;
            timer_d = dead_len_q - 1'b1;
          end
        end else begin
          count_d = cnt_inc;
          timer_d = timer_q - 1'b1;
        end
      end
      S_DEAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_GATE;
          timer_d = gate_len_q - 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept empties the slot; a close may refill it the same cycle.
    if (m_axis.tready) tvalid_d = 1'b0;
    if (close) begin
      if (!tvalid_q || m_axis.tready) begin
        tvalid_d = 1'b1;
        tdata_d  = {win_idx_q, cnt_inc};
      end else begin
        overrun_d = 1'b1;
      end
    end

    qualify = close && thr_q != '0 && cnt_inc >= thr_q;
    if (qualify) trig_cnt_d = TRIG_W'(TRIG_LEN);
    else if (trig_cnt_q != '0) trig_cnt_d = trig_cnt_q - 1'b1;
    else trig_cnt_d = '0;
    trig_d = (trig_cnt_d != '0);

    gate_d = (state_d == S_GATE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      gate_len_q <= '0;
      dead_len_q <= '0;
      num_win_q  <= '0;
      thr_q      <= '0;
      count_q    <= '0;
      win_idx_q  <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
      trig_cnt_q <= '0;
      trig_q     <= 1'b0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gate_len_q <= gate_len_d;
      dead_len_q <= dead_len_d;
      num_win_q  <= num_win_d;
      thr_q      <= thr_d;
      count_q    <= count_d;
      win_idx_q  <= win_idx_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      overrun_q  <= overrun_d;
      trig_cnt_q <= trig_cnt_d;
      trig_q     <= trig_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign gate          = gate_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign trig_out      = trig_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_photon_gate_sequencer.sv
// Directed bench for photon_gate_sequencer: vector table of whole runs
// plus hand sequences for backpressure, abort, saturation and reset.
module tb_photon_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        edge_in = 1'b0;
  logic [31:0] cfg_gate_len = '0;
  logic [31:0] cfg_dead_len = '0;
  logic [15:0] cfg_num_windows = '0;
  logic [15:0] cfg_threshold = '0;
  logic        gate, busy, done, trig_out, overrun;

  photon_gate_sequencer_if axis();

  photon_gate_sequencer #(.TRIG_LEN(125), .TIMER_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .edge_in         (edge_in),
    .cfg_gate_len    (cfg_gate_len),
    .cfg_dead_len    (cfg_dead_len),
    .cfg_num_windows (cfg_num_windows),
    .cfg_threshold   (cfg_threshold),
    .gate            (gate),
    .busy            (busy),
    .done            (done),
    .m_axis          (axis),
    .trig_out        (trig_out),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          gl;
    int          dl;
    int          nw;
    int          thr;
    logic [31:0] m0;
    logic [31:0] m1;
    bit          de;
    logic [15:0] e0;
    logic [15:0] e1;
    int          trig;
  } vec_t;

  vec_t vecs[7];

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int gl, gcnt, res, gate_hi, low_busy, trig_cyc, cyc, pos, win;
    bit fin, prev_gate;
    logic [15:0] idx;
    logic [31:0] mask;
    gl = (v.gl == 0) ? 1 : v.gl;
    cfg_gate_len    = v.gl;
    cfg_dead_len    = v.dl;
    cfg_num_windows = 16'(v.nw);
    cfg_threshold   = 16'(v.thr);
    axis.tready     = 1'b1;
    gcnt = 0; res = 0; gate_hi = 0; low_busy = 0;
    trig_cyc = 0; cyc = 0; fin = 0; prev_gate = 0; idx = '0;
    pulse_start();
    chk($sformatf("v%0d_start_gate", n), gate, 1);
    chk($sformatf("v%0d_start_busy", n), busy, 1);
    while (!fin && cyc < 5000) begin
      if (trig_out) trig_cyc++;
      if (axis.tvalid) begin
        chk($sformatf("v%0d_tdata%0d", n, idx), axis.tdata,
            {idx, (idx == 0) ? v.e0 : v.e1});
        idx++;
        res++;
      end
      if (done) begin
        fin = 1;
        chk($sformatf("v%0d_done_busy", n), busy, 0);
        chk($sformatf("v%0d_done_after_gate", n), prev_gate, 1);
      end
      prev_gate = gate;
      if (gate) begin
        pos  = gcnt % gl;
        win  = gcnt / gl;
        mask = (win == 0) ? v.m0 : v.m1;
        edge_in = (pos < 32) ? mask[pos] : 1'b0;
        gate_hi++;
        gcnt++;
      end else begin
        edge_in = busy && v.de;
        if (busy) low_busy++;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    edge_in = 1'b0;
    chk($sformatf("v%0d_finished", n), fin, 1);
    @(negedge clk);
    chk($sformatf("v%0d_tvalid_drop", n), axis.tvalid, 0);
    cyc = 0;
    while (trig_out && cyc < 300) begin
      trig_cyc++;
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_results", n), res, v.nw);
    chk($sformatf("v%0d_gate_cycles", n), gate_hi, v.nw * gl);
    chk($sformatf("v%0d_dead_cycles", n), low_busy, (v.nw - 1) * v.dl);
    chk($sformatf("v%0d_trig_cycles", n), trig_cyc, v.trig);
  endtask

  initial begin
    int cyc, res;
    bit seen;

    vecs[0] = '{10, 5, 3, 0, 32'hF, 32'hF, 1'b0, 16'd4, 16'd4, 0};
    vecs[1] = '{5, 3, 2, 0, 32'h11, 32'h11, 1'b1, 16'd2, 16'd2, 0};
    vecs[2] = '{8, 2, 2, 3, 32'h3, 32'h1F, 1'b0, 16'd2, 16'd5, 125};
    vecs[3] = '{45, 5, 2, 1, 32'h1, 32'h1, 1'b0, 16'd1, 16'd1, 175};
    vecs[4] = '{0, 0, 2, 1, 32'h1, 32'h1, 1'b0, 16'd1, 16'd1, 126};
    vecs[5] = '{6, 0, 2, 7, 32'h3F, 32'h3F, 1'b0, 16'd6, 16'd6, 0};
    vecs[6] = '{4, 2, 2, 4, 32'hF, 32'hF, 1'b0, 16'd4, 16'd4, 131};

    axis.tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gate", gate, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tdata", axis.tdata, 0);
    chk("rst_trig", trig_out, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Backpressure: only window 0 survives, later results dropped.
    cfg_gate_len = 4; cfg_dead_len = 1;
    cfg_num_windows = 3; cfg_threshold = 0;
    axis.tready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!done && cyc < 200) begin
      edge_in = gate;
      if (axis.tvalid) chk("bp_hold", axis.tdata, {16'd0, 16'd4});
      @(negedge clk);
      cyc++;
    end
    edge_in = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_overrun", overrun, 1);
    chk("bp_tvalid", axis.tvalid, 1);
    chk("bp_tdata", axis.tdata, {16'd0, 16'd4});
    axis.tready = 1'b1;
    @(negedge clk);
    chk("bp_accept_drop", axis.tvalid, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (axis.tvalid) seen = 1;
    end
    chk("bp_no_more", seen, 0);
    chk("bp_overrun_sticky", overrun, 1);

    // Continuous run, abort mid-gate of window 1.
    cfg_gate_len = 10; cfg_dead_len = 0;
    cfg_num_windows = 0; cfg_threshold = 0;
    pulse_start();
    chk("cont_overrun_clr", overrun, 0);
    res = 0;
    for (int i = 0; i < 15; i++) begin
      edge_in = gate;
      if (axis.tvalid) begin
        res++;
        chk("cont_res", axis.tdata, {16'd0, 16'd10});
      end
      @(negedge clk);
    end
    chk("cont_res_cnt", res, 1);
    chk("cont_gate_on", gate, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    edge_in = 1'b0;
    chk("abort_gate", gate, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tvalid", axis.tvalid, 0);
    chk("abort_done", done, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (axis.tvalid || done || busy) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_gate", gate, 0);

    // Saturation over a 70000-cycle gate, then async reset mid-gate.
    cfg_gate_len = 70000; cfg_dead_len = 0;
    cfg_num_windows = 1; cfg_threshold = 1;
    axis.tready = 1'b0;
    edge_in = 1'b1;
    pulse_start();
    cyc = 0;
    while (!done && cyc < 70100) begin
      @(negedge clk);
      cyc++;
    end
    chk("sat_done", done, 1);
    chk("sat_tdata", axis.tdata, {16'd0, 16'hFFFF});
    chk("sat_tvalid", axis.tvalid, 1);
    chk("sat_trig", trig_out, 1);
    cfg_gate_len = 1000;
    pulse_start();
    chk("rst2_gate", gate, 1);
    repeat (50) @(negedge clk);
    chk("rst2_trig_pre", trig_out, 1);
    chk("rst2_tvalid_pre", axis.tvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_gate", gate, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_tvalid", axis.tvalid, 0);
    chk("arst_tdata", axis.tdata, 0);
    chk("arst_trig", trig_out, 0);
    chk("arst_overrun", overrun, 0);
    edge_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
